// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage access controller: funct3 codes, FSM state encodings
// and the funct3 legality check used to bypass the memory port.
package mem_access_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Unsigned widths exist only for loads.
    function automatic logic f3_illegal(input logic we, input logic [2:0] funct3);
        return (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111) ||
               (we && funct3[2]);
    endfunction

endpackage

// File: rtl/mem_access_ctrl_load_align.sv
// Combinational load lane select: picks the byte/halfword addressed by the low address bits
// and sign- or zero-extends it to 32 bits.
module mem_access_ctrl_load_align
    import mem_access_ctrl_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        case (offset)
            2'b00:   byte_lane = word[7:0];
            2'b01:   byte_lane = word[15:8];
            2'b10:   byte_lane = word[23:16];
            default: byte_lane = word[31:24];
        endcase
        half_lane = offset[1] ? word[31:16] : word[15:0];

        case (funct3)
            F3_LB:   data = {{24{byte_lane[7]}}, byte_lane};
            F3_LH:   data = {{16{half_lane[15]}}, half_lane};
            F3_LW:   data = word;
            F3_LBU:  data = {24'b0, byte_lane};
            F3_LHU:  data = {16'b0, half_lane};
            default: data = 32'b0;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data memory access controller: one outstanding load/store, variable-latency ack with
// timeout, load extension and store lane replication. Optional MEM_MISALIGN_TRAP_EN traps misaligned accesses.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_en,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

    state_t      state, state_next;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [7:0]  wait_cnt;
    logic        bypass;
    logic        timeout;
    logic [31:0] load_data;

    always_comb begin
        bypass = f3_illegal(req_we, req_funct3);
`ifdef MEM_MISALIGN_TRAP_EN
        if ((req_funct3[1:0] == 2'b01) && req_addr[0])
            bypass = 1'b1;
        if ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00))
            bypass = 1'b1;
`endif
    end

    assign timeout = (wait_cnt == LAST_WAIT);

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (req_valid) state_next = bypass ? ST_RESP : ST_ACCESS;
            ST_ACCESS: if (mem_ack || timeout) state_next = ST_RESP;
            ST_RESP:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wait_cnt <= 8'd0;
        else if (state != ST_ACCESS)
            wait_cnt <= 8'd0;
        else if (!mem_ack)
            wait_cnt <= wait_cnt + 8'd1;
    end

    // Request fields only matter while the FSM is busy, so they carry no reset.
    always_ff @(posedge clk) begin
        if ((state == ST_IDLE) && req_valid) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
        end
    end

    mem_access_ctrl_load_align u_load_align (
        .word   (mem_rdata),
        .offset (addr_q[1:0]),
        .funct3 (funct3_q),
        .data   (load_data)
    );

    // Response registers hold a value only during RESP; ack wins over a simultaneous timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_rdata <= 32'b0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_rdata <= 32'b0;
            rsp_err   <= 1'b0;
            case (state)
                ST_IDLE:   rsp_err <= req_valid && bypass;
                ST_ACCESS: begin
                    if (mem_ack)
                        rsp_rdata <= we_q ? 32'b0 : load_data;
                    else if (timeout)
                        rsp_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign mem_en    = (state == ST_ACCESS);

    always_comb begin
        mem_addr  = 32'b0;
        mem_we    = 4'b0000;
        mem_wdata = 32'b0;
        if (mem_en) begin
            mem_addr = {addr_q[31:2], 2'b00};
            if (we_q) begin
                case (funct3_q[1:0])
                    2'b00: begin
                        mem_we    = 4'b0001 << addr_q[1:0];
                        mem_wdata = {4{wdata_q[7:0]}};
                    end
                    2'b01: begin
                        mem_we    = addr_q[1] ? 4'b1100 : 4'b0011;
                        mem_wdata = {2{wdata_q[15:0]}};
                    end
                    default: begin
                        mem_we    = 4'b1111;
                        mem_wdata = wdata_q;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: a per-transaction model queues the expected output vector of every
// cycle and one process compares the DUT against it on each falling edge.
module tb_mem_access_ctrl;

    localparam int MAX_WAIT = 15;

    typedef struct packed {
        logic        req_ready;
        logic        rsp_valid;
        logic        rsp_err;
        logic [31:0] rsp_rdata;
        logic        mem_en;
        logic [3:0]  mem_we;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b0;
    logic [31:0] req_addr = 32'b0;
    logic [31:0] req_wdata = 32'b0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'b0;
    logic        mem_ack = 1'b0;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    obs_t exp_q[$];

    logic [31:0] last_rdata;
    logic        last_err;
    logic [3:0]  last_we;
    logic [31:0] last_wdata;
    logic [31:0] last_addr;
    int          en_cnt;
    int          rsp_cnt;

    mem_access_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    always #5 clk = ~clk;

    function automatic obs_t idle_obs();
        obs_t o;
        o = '0;
        o.req_ready = 1'b1;
        return o;
    endfunction

    function automatic bit model_bypass(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        bit b;
        b = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && f3 >= 3'd4);
`ifdef MEM_MISALIGN_TRAP_EN
        if ((f3 == 3'd1 || f3 == 3'd5) && (addr % 2 != 0)) b = 1'b1;
        if (f3 == 3'd2 && (addr % 4 != 0)) b = 1'b1;
`endif
        return b;
    endfunction

    function automatic logic [31:0] load_model(input logic [31:0] word, input logic [31:0] addr,
                                               input logic [2:0] f3);
        logic [31:0] v;
        int sh;
        case (f3)
            3'd0, 3'd4: begin
                sh = 8 * int'(addr % 4);
                v = (word >> sh) & 32'hFF;
                if (f3 == 3'd0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
            end
            3'd1, 3'd5: begin
                sh = ((addr % 4) >= 2) ? 16 : 0;
                v = (word >> sh) & 32'hFFFF;
                if (f3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
            end
            default: v = word;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] we_model(input logic [2:0] f3, input logic [31:0] addr);
        case (f3)
            3'd0:    return 4'(1 << (addr % 4));
            3'd1:    return ((addr % 4) >= 2) ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] wdata_model(input logic [2:0] f3, input logic [31:0] wdata);
        case (f3)
            3'd0:    return (wdata & 32'hFF) * 32'h0101_0101;
            3'd1:    return (wdata & 32'hFFFF) * 32'h0001_0001;
            default: return wdata;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        obs_t e;
        obs_t a;
        if (chk_en) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : idle_obs();
            a = '{req_ready, rsp_valid, rsp_err, rsp_rdata, mem_en, mem_we, mem_addr, mem_wdata};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL cycle t=%0t got rdy=%b vld=%b err=%b rd=%h en=%b we=%b a=%h wd=%h expected rdy=%b vld=%b err=%b rd=%h en=%b we=%b a=%h wd=%h",
                         $time, a.req_ready, a.rsp_valid, a.rsp_err, a.rsp_rdata, a.mem_en, a.mem_we,
                         a.mem_addr, a.mem_wdata, e.req_ready, e.rsp_valid, e.rsp_err, e.rsp_rdata,
                         e.mem_en, e.mem_we, e.mem_addr, e.mem_wdata);
            end
            if (rsp_valid) begin
                last_rdata = rsp_rdata;
                last_err   = rsp_err;
                rsp_cnt++;
            end
            if (mem_en) begin
                last_we    = mem_we;
                last_wdata = mem_wdata;
                last_addr  = mem_addr;
                en_cnt++;
            end
        end
    end

    // d = number of ACCESS cycles before the ack cycle; d < 0 means ack never comes.
    task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata, input int d);
        obs_t o;
        int   n;
        bit   err;
        exp_q.push_back(idle_obs());
        if (model_bypass(we, f3, addr)) begin
            n = 0;
            o = '0;
            o.rsp_valid = 1'b1;
            o.rsp_err   = 1'b1;
            exp_q.push_back(o);
        end else begin
            if (d >= 0 && d < MAX_WAIT) begin n = d + 1; err = 1'b0; end
            else begin n = MAX_WAIT; err = 1'b1; end
            o = '0;
            o.mem_en    = 1'b1;
            o.mem_addr  = addr & 32'hFFFF_FFFC;
            o.mem_we    = we ? we_model(f3, addr) : 4'b0000;
            o.mem_wdata = we ? wdata_model(f3, wdata) : 32'b0;
            repeat (n) exp_q.push_back(o);
            o = '0;
            o.rsp_valid = 1'b1;
            o.rsp_err   = err;
            o.rsp_rdata = (err || we) ? 32'b0 : load_model(rdata, addr, f3);
            exp_q.push_back(o);
        end
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        for (int c = 1; c <= n; c++) begin
            @(posedge clk); #1;
            req_valid = 1'b0; req_addr = ~addr; req_wdata = ~wdata; req_funct3 = ~f3;
            mem_ack   = (c == d + 1);
            mem_rdata = (c == d + 1) ? rdata : ~rdata;
        end
        @(posedge clk); #1;
        req_valid = 1'b0; mem_ack = 1'b0; mem_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", 32'(req_ready), 32'd1);
        chk("reset_en", 32'(mem_en), 32'd0);
        chk("reset_rsp", {rsp_valid, rsp_err, 30'b0} | rsp_rdata, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;

        // Lb from top byte, immediate ack
        run(1'b0, 3'd0, 32'h0000_1003, 32'h0, 32'h80FF_0000, 0);
        chk("lb_rdata", last_rdata, 32'hFFFF_FF80);
        chk("lb_err", 32'(last_err), 32'd0);
        // Lhu upper half after three wait cycles
        run(1'b0, 3'd5, 32'h0000_2002, 32'h0, 32'h8001_1234, 3);
        chk("lhu_rdata", last_rdata, 32'h0000_8001);
        chk("lhu_addr", last_addr, 32'h0000_2000);
        // Sb into lane 1
        run(1'b1, 3'd0, 32'h0000_3001, 32'h0000_00AB, 32'h1111_1111, 0);
        chk("sb_we", 32'(last_we), 32'h2);
        chk("sb_wdata", last_wdata, 32'hABAB_ABAB);
        chk("sb_rdata", last_rdata, 32'h0);
        // Lw never acked: timeout
        en_cnt = 0;
        run(1'b0, 3'd2, 32'h0000_5000, 32'h0, 32'h5555_5555, -1);
        chk("to_en_cycles", 32'(en_cnt), 32'(MAX_WAIT));
        chk("to_err", 32'(last_err), 32'd1);
        // ack on the last permitted cycle counts as an ack
        run(1'b0, 3'd2, 32'h0000_5004, 32'h0, 32'hCAFE_F00D, MAX_WAIT - 1);
        chk("edge_ack_rdata", last_rdata, 32'hCAFE_F00D);
        // illegal funct3 values
        en_cnt = 0;
        run(1'b0, 3'd3, 32'h0000_6000, 32'h0, 32'h0, 0);
        run(1'b1, 3'd4, 32'h0000_6000, 32'h0, 32'h0, 0);
        chk("illegal_en", 32'(en_cnt), 32'd0);
        chk("illegal_err", 32'(last_err), 32'd1);
        // misaligned Sw
        en_cnt = 0;
        run(1'b1, 3'd2, 32'h0000_4002, 32'h1234_5678, 32'h0, 0);
`ifdef MEM_MISALIGN_TRAP_EN
        chk("sw_mis_err", 32'(last_err), 32'd1);
        chk("sw_mis_en", 32'(en_cnt), 32'd0);
`else
        chk("sw_mis_addr", last_addr, 32'h0000_4000);
        chk("sw_mis_we", 32'(last_we), 32'hF);
`endif
        // further lane and sign cases
        run(1'b0, 3'd1, 32'h0000_7002, 32'h0, 32'h8001_1234, 1);
        chk("lh_rdata", last_rdata, 32'hFFFF_8001);
        run(1'b0, 3'd4, 32'h0000_7001, 32'h0, 32'h0000_9A00, 2);
        chk("lbu_rdata", last_rdata, 32'h0000_009A);
        run(1'b0, 3'd0, 32'h0000_7000, 32'h0, 32'hFFFF_FF7F, 0);
        run(1'b1, 3'd1, 32'h0000_8002, 32'h1234_BEEF, 32'h0, 2);
        chk("sh_we", 32'(last_we), 32'hC);
        chk("sh_wdata", last_wdata, 32'hBEEF_BEEF);
        run(1'b0, 3'd1, 32'h0000_8001, 32'h0, 32'h00FF_7F80, 0);
        run(1'b1, 3'd2, 32'h0000_9000, 32'hA5A5_0F0F, 32'h0, 4);

        // asynchronous reset in the middle of an access
        chk_en = 1'b0;
        rsp_cnt = 0;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h0000_A000;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rst_pre_en", 32'(mem_en), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_en_drop", 32'(mem_en), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        mem_ack = 1'b1;
        rst_n = 1'b1;
        exp_q.delete();
        chk_en = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        mem_ack = 1'b0;
        chk("rst_no_rsp", 32'(rsp_cnt), 32'd0);
        run(1'b0, 3'd2, 32'h0000_B000, 32'h0, 32'h0BAD_F00D, 0);
        chk("post_rst_rdata", last_rdata, 32'h0BAD_F00D);

        @(posedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
